// File: rtl/pass_lock_fsm.sv
// pass_lock_fsm: sequential code lock.
// Collects DIGITS digits, one per digit_valid strobe, and compares each digit
// against the stored code as it arrives. A full match opens the lock. Too many
// failed attempts start a timed lockout with alarm.
// Optional macro PASS_LOCK_REPROG_EN: while the lock is open, prog_valid loads a
// new code. When the macro is undefined, the stored code is fixed at
// DEFAULT_PASS.
//
// state   | meaning
// --------+------------------------------------------------------------
// ENTRY   | collecting digits, building the sticky mismatch flag
// CHECK   | one-cycle evaluation of the completed entry (busy=1)
// OPEN    | lock open; relocks on lock_req or on open-timer expiry
// LOCKOUT | timed penalty after MAX_TRIES failures (alarm=1)
module pass_lock_fsm #(
  parameter int                        PASS_W       = 4,
  parameter int                        DIGITS       = 4,
  parameter logic [PASS_W*DIGITS-1:0]  DEFAULT_PASS = 16'h4321,
  parameter int                        MAX_TRIES    = 3,
  parameter int                        LOCK_CYCLES  = 16,
  parameter int                        OPEN_CYCLES  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PASS_W-1:0]                digit_in,
  input  logic                             digit_valid,
  input  logic                             clear,
  input  logic                             lock_req,
  input  logic                             prog_valid,
  input  logic [PASS_W*DIGITS-1:0]         prog_code,
  output logic                             unlocked,
  output logic                             alarm,
  output logic                             busy,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [$clog2(DIGITS+1)-1:0]      digit_cnt
);

  localparam int CW   = $clog2(DIGITS+1);
  localparam int TRW  = $clog2(MAX_TRIES+1);
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Timers are down-counters loaded with (duration-1) on state entry; the exit
  // fires when they reach zero, so the state lasts exactly 'duration' clocks.
  localparam logic [TW-1:0]  OPEN_LOAD  = TW'((OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 0);
  localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [TRW-1:0] TRIES_INIT = TRW'(MAX_TRIES);
  localparam logic [CW-1:0]  LAST_IDX   = CW'(DIGITS - 1);

  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;

  state_t                    state;
  logic                      mismatch;
  logic [TW-1:0]             timer;
  logic [PASS_W*DIGITS-1:0]  code;
  logic [PASS_W-1:0]         cur_digit;

`ifdef PASS_LOCK_REPROG_EN
  // Stored code register: reloadable only while open, restored on reset.
  always_ff @(posedge clk) begin
    if (!rst_n)
      code <= DEFAULT_PASS;
    else if (state == OPEN && prog_valid)
      code <= prog_code;
  end
`else
  assign code = DEFAULT_PASS;

  // Programming port is present for pin compatibility only.
  logic unused_prog;
  assign unused_prog = ^{prog_valid, prog_code};
`endif

  // Select the stored digit that the next entered digit is compared against.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (digit_cnt == CW'(i))
        cur_digit = code[i*PASS_W +: PASS_W];
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ENTRY;
      digit_cnt  <= '0;
      mismatch   <= 1'b0;
      tries_left <= TRIES_INIT;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (clear) begin
            digit_cnt <= '0;
            mismatch  <= 1'b0;
          end else if (digit_valid) begin
            mismatch  <= mismatch | (digit_in != cur_digit);
            digit_cnt <= digit_cnt + 1'b1;
            if (digit_cnt == LAST_IDX) begin
              state <= CHECK;
              busy  <= 1'b1;
            end
          end
        end

        CHECK: begin
          busy      <= 1'b0;
          digit_cnt <= '0;
          mismatch  <= 1'b0;
          if (!mismatch) begin
            state      <= OPEN;
            unlocked   <= 1'b1;
            tries_left <= TRIES_INIT;
            timer      <= OPEN_LOAD;
          end else if (tries_left > TRW'(1)) begin
            state      <= ENTRY;
            tries_left <= tries_left - 1'b1;
          end else begin
            state      <= LOCKOUT;
            alarm      <= 1'b1;
            tries_left <= '0;
            timer      <= LOCK_LOAD;
          end
        end

        OPEN: begin
          // lock_req and timer expiry in the same cycle collapse to one relock.
          if (lock_req || (OPEN_CYCLES > 0 && timer == '0)) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
          end else if (OPEN_CYCLES > 0) begin
            timer <= timer - 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            state      <= ENTRY;
            alarm      <= 1'b0;
            tries_left <= TRIES_INIT;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state <= ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pass_lock_fsm.sv
// Directed self-checking bench for pass_lock_fsm with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked at the
// same point, so each check sees the state right after the preceding edge.
module tb_pass_lock_fsm;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        clear;
  logic        lock_req;
  logic        prog_valid;
  logic [15:0] prog_code;
  logic        unlocked;
  logic        alarm;
  logic        busy;
  logic [1:0]  tries_left;
  logic [2:0]  digit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pass_lock_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .clear       (clear),
    .lock_req    (lock_req),
    .prog_valid  (prog_valid),
    .prog_code   (prog_code),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .busy        (busy),
    .tries_left  (tries_left),
    .digit_cnt   (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // Enters four digits (digit i = code[4i+:4]) and lets CHECK resolve.
  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) send_digit(code[i*4 +: 4]);
    tick();
  endtask

  task automatic relock();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_unl"},   32'(unlocked),   0);
    check_eq({tag, "_alarm"}, 32'(alarm),      0);
    check_eq({tag, "_cnt"},   32'(digit_cnt),  0);
    check_eq({tag, "_tries"}, 32'(tries_left), 3);
  endtask

  initial begin
    int n;
    int bad_cnt;

    rst_n = 1'b0; digit_in = '0; digit_valid = 1'b0; clear = 1'b0;
    lock_req = 1'b0; prog_valid = 1'b0; prog_code = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_reset_vals("rst0");
    check_eq("rst0_busy", 32'(busy), 0);

    // Correct code 1,2,3,4 on consecutive cycles.
    send_digit(4'd1); check_eq("cnt1", 32'(digit_cnt), 1);
    send_digit(4'd2); check_eq("cnt2", 32'(digit_cnt), 2);
    send_digit(4'd3); check_eq("cnt3", 32'(digit_cnt), 3);
    send_digit(4'd4);
    check_eq("chk_busy", 32'(busy), 1);
    check_eq("chk_unl0", 32'(unlocked), 0);
    // A digit offered during CHECK must be dropped.
    digit_in = 4'd1; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    check_eq("open_busy",  32'(busy), 0);
    check_eq("open_unl",   32'(unlocked), 1);
    check_eq("open_tries", 32'(tries_left), 3);
    check_eq("open_cnt",   32'(digit_cnt), 0);
    // Digits ignored while open.
    send_digit(4'd1);
    check_eq("open_dig_ign", 32'(digit_cnt), 0);
    check_eq("open_busy2",   32'(busy), 0);
    relock();
    check_eq("relock_unl", 32'(unlocked), 0);

    // Wrong code then correct code.
    enter_code(16'h5321);
    check_eq("bad1_unl",   32'(unlocked), 0);
    check_eq("bad1_tries", 32'(tries_left), 2);
    check_eq("bad1_cnt",   32'(digit_cnt), 0);
    enter_code(16'h4321);
    check_eq("good_unl",   32'(unlocked), 1);
    check_eq("good_tries", 32'(tries_left), 3);
    relock();

    // Three failures -> lockout lasting 16 cycles with digits ignored.
    enter_code(16'h0000);
    check_eq("lk_t2", 32'(tries_left), 2);
    enter_code(16'h4320);
    check_eq("lk_t1", 32'(tries_left), 1);
    enter_code(16'h1234);
    check_eq("lk_alarm", 32'(alarm), 1);
    check_eq("lk_t0",    32'(tries_left), 0);
    n = 1;
    bad_cnt = 0;
    digit_in = 4'd1; digit_valid = 1'b1; clear = 1'b1;
    while (alarm && n < 40) begin
      if (n == 15) begin digit_valid = 1'b0; clear = 1'b0; end
      tick();
      if (digit_cnt != 0) bad_cnt++;
      if (alarm) n++;
    end
    digit_valid = 1'b0; clear = 1'b0;
    check_eq("lk_len",     32'(n), 16);
    check_eq("lk_dig_ign", 32'(bad_cnt), 0);
    check_eq("lk_end_tries", 32'(tries_left), 3);
    enter_code(16'h4321);
    check_eq("lk_after_unl", 32'(unlocked), 1);
    relock();

    // Clear together with a digit: clear wins.
    send_digit(4'd1);
    send_digit(4'd2);
    check_eq("clr_pre", 32'(digit_cnt), 2);
    digit_in = 4'd3; digit_valid = 1'b1; clear = 1'b1;
    tick();
    digit_valid = 1'b0; clear = 1'b0;
    check_eq("clr_cnt", 32'(digit_cnt), 0);
    enter_code(16'h4321);
    check_eq("clr_unl",   32'(unlocked), 1);
    check_eq("clr_tries", 32'(tries_left), 3);

    // Auto-relock: open for exactly 32 cycles.
    n = 0;
    while (unlocked && n < 100) begin
      tick();
      n++;
    end
    check_eq("timeout_len", 32'(n), 32);

    // Reset in OPEN.
    enter_code(16'h4321);
    check_eq("ro_pre", 32'(unlocked), 1);
    do_reset();
    check_reset_vals("rst_open");

    // Reset in LOCKOUT, with digits offered while reset is held.
    enter_code(16'h0000);
    enter_code(16'h0000);
    enter_code(16'h0000);
    check_eq("rl_pre", 32'(alarm), 1);
    digit_in = 4'd1; digit_valid = 1'b1;
    do_reset();
    digit_valid = 1'b0;
    check_reset_vals("rst_lock");

    // Reset after two digits.
    send_digit(4'd1);
    send_digit(4'd2);
    check_eq("rd_pre", 32'(digit_cnt), 2);
    do_reset();
    check_reset_vals("rst_dig");

`ifdef PASS_LOCK_REPROG_EN
    enter_code(16'h4321);
    prog_code = 16'h9876; prog_valid = 1'b1; lock_req = 1'b1;
    tick();
    prog_valid = 1'b0; lock_req = 1'b0;
    check_eq("pg_relock", 32'(unlocked), 0);
    enter_code(16'h4321);
    check_eq("pg_old_unl",   32'(unlocked), 0);
    check_eq("pg_old_tries", 32'(tries_left), 2);
    enter_code(16'h9876);
    check_eq("pg_new_unl", 32'(unlocked), 1);
    relock();
    prog_code = 16'h1111; prog_valid = 1'b1;
    tick();
    prog_valid = 1'b0;
    enter_code(16'h9876);
    check_eq("pg_entry_ign", 32'(unlocked), 1);
    relock();
    do_reset();
    enter_code(16'h4321);
    check_eq("pg_rst_default", 32'(unlocked), 1);
    relock();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
